vxc_row_mem_server: RTL and testbench
=====================================

// Module: vxc_row_mem_server
// PURPOSE
//   Memory-side responder for the conjugate vXc mul/add row controller. Answers each read_again
//   request by fetching the next row pair from operand memories A/B. Returns it on
//   first_row_fixed/second_row_fixed. Captures vXc_add_8_output into result memory on every
//   result_mem_we. Sits between the operand/result RAMs and the vXc controller.
// PARAMETERS
//   element_width  64  bits per complex element
//   no_of_units    8   elements per row (row = element_width*no_of_units bits)
//   addr_width     10  row-address width of operand and result memories
// PORTS
//   clk               in   1      single clock, rising edge
//   reset             in   1      asynchronous, active-low (0 = reset)
//   start             in   1      one-cycle pulse, begins a job; honoured only in IDLE
//   total             in   32     element count of job; rows = total/no_of_units (floor)
//   read_again        in   1      consumer request for next row; rising edge = one request
//   first_row_fixed   out  E*N    registered row from memory A
//   second_row_fixed  out  E*N    registered row from memory B
//   row_valid         out  1      rows on outputs are current
//   mem_a_rd_en       out  1      memory A read strobe (sync RAM, 1-cycle read latency)
//   mem_b_rd_en       out  1      memory B read strobe, always equal to mem_a_rd_en
//   mem_rd_addr       out  AW     shared row read address for A and B
//   mem_a_rdata       in   E*N    memory A data, valid 1 cycle after rd_en
//   mem_b_rdata       in   E*N    memory B data, valid 1 cycle after rd_en
//   result_mem_we     in   1      consumer write strobe; each high cycle = one result row
//   vXc_add_8_output  in   E*N    result row, sampled while result_mem_we=1
//   res_we            out  1      result RAM write enable
//   res_addr          out  AW     result RAM row address
//   res_wdata         out  E*N    result RAM write data
//   done              out  1      sticky; all rows fetched and all results written
//   overflow          out  1      sticky; result_mem_we seen after rows results already written
// BEHAVIOUR
//   Reset (async, reset=0): all outputs 0; state IDLE; fetch/write counters 0; pending flag 0.
//   FSM: IDLE -start-> PREFETCH (row 0 read) -> SERVE -all rows fetched-> DRAIN
//        -writes==rows-> DONE. DONE -start-> PREFETCH (done/overflow cleared).
//   start with rows==0: IDLE -> DONE in 1 cycle, no memory access.
//   start outside IDLE/DONE: ignored.
//   Fetch: rd_en high 1 cycle with mem_rd_addr=fetch_cnt. Data registered to outputs on the next
//     edge; row_valid=1, fetch_cnt++. Row 0 is issued the cycle after start.
//   Request: read_again rising edge sampled at edge N -> rd_en at cycle N+1 -> new row on outputs
//     after edge N+2.
//     row_valid falls at edge N+1 and rises at N+2.
//     Held-high read_again counts once.
//   Rise while a fetch is in flight: stored in a 1-deep pending flag, issued the cycle after
//     current data lands. A further rise while pending is set is dropped.
//   Rise when fetch_cnt==rows: ignored, no memory access, outputs hold.
//   Write path (independent of fetch path): result_mem_we=1 at edge N -> res_we=1,
//     res_addr=wr_cnt, res_wdata=vXc_add_8_output during cycle N+1; wr_cnt++.
//     Back-to-back strobes write consecutive addresses.
//   Write with wr_cnt==rows: no res_we, overflow set (sticky until next start or reset).
//   read_again rise and result_mem_we in same cycle: both serviced, no interaction.
//   Reset mid-job: immediate abort to IDLE; in-flight read data discarded; res_we drops at once.
//   Address counters are addr_width bits. rows > 2^addr_width is a caller error; addresses wrap.
// STRUCTURE
//   vxc_pkg: state enum (IDLE, PREFETCH, SERVE, DRAIN, DONE); ROW_W=element_width*no_of_units.
//   Sub-module vxc_result_writer: wr_cnt, res_* registers, overflow.
//     Top level holds FSM, fetch counter, edge detect, pending flag.
// TESTING
//   T1 total=64, N=8, start; 8 single-cycle read_again rises 4 cycles apart -> rows 0..7 in order;
//      row k on outputs 2 cycles after kth rise; done only after 8 writes.
//   T2 total=20 (rows=2); 3 read_again rises -> only addrs 0,1 read; third rise causes no rd_en.
//   T3 two rises 1 cycle apart -> second serviced via pending flag; addrs consecutive, no row lost.
//   T4 3 back-to-back result_mem_we with rows=2 -> res_addr 0,1 written; third suppressed;
//      overflow=1.
//   T5 reset=0 pulsed mid-row-3 fetch -> all outputs 0 immediately; new start refetches from addr 0.
//   T6 total=5 (rows=0) start -> done=1 next cycle, no rd_en, no res_we.

Source files
------------

// File: rtl/vxc_pkg.sv
// Shared types and default sizing for the vXc row memory server.
package vxc_pkg;

  localparam int ELEMENT_WIDTH = 64;
  localparam int NO_OF_UNITS   = 8;
  localparam int ADDR_WIDTH    = 10;
  localparam int ROW_W         = ELEMENT_WIDTH * NO_OF_UNITS;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREFETCH = 3'd1,
    ST_SERVE    = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

endpackage

// File: rtl/vxc_result_writer.sv
// Result path: turns each result_mem_we strobe into one registered result-RAM
// write at the next row address, and flags strobes that arrive after the last
// row of the job has been written.
module vxc_result_writer
  import vxc_pkg::*;
#(
  parameter int row_w      = ROW_W,
  parameter int addr_width = ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_i,
  input  logic [31:0]           rows_i,
  input  logic                  result_mem_we_i,
  input  logic [row_w-1:0]      wdata_i,
  output logic                  res_we_o,
  output logic [addr_width-1:0] res_addr_o,
  output logic [row_w-1:0]      res_wdata_o,
  output logic                  overflow_o,
  output logic                  wr_full_o
);

  logic [31:0]           wr_cnt_q, wr_cnt_d;
  logic                  res_we_q, res_we_d;
  logic [addr_width-1:0] res_addr_q, res_addr_d;
  logic [row_w-1:0]      res_wdata_q, res_wdata_d;
  logic                  overflow_q, overflow_d;

  // Accept a strobe while rows remain, otherwise record the overflow.
  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    res_we_d    = 1'b0;
    res_addr_d  = res_addr_q;
    res_wdata_d = res_wdata_q;
    overflow_d  = overflow_q;
    if (clr_i) begin
      wr_cnt_d   = '0;
      overflow_d = 1'b0;
    end else if (result_mem_we_i) begin
      if (wr_cnt_q < rows_i) begin
        res_we_d    = 1'b1;
        res_addr_d  = wr_cnt_q[addr_width-1:0];
        res_wdata_d = wdata_i;
        wr_cnt_d    = wr_cnt_q + 32'd1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // Result-side registers; reset drops res_we immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt_q    <= '0;
      res_we_q    <= 1'b0;
      res_addr_q  <= '0;
      res_wdata_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      res_we_q    <= res_we_d;
      res_addr_q  <= res_addr_d;
      res_wdata_q <= res_wdata_d;
      overflow_q  <= overflow_d;
    end
  end

  assign res_we_o    = res_we_q;
  assign res_addr_o  = res_addr_q;
  assign res_wdata_o = res_wdata_q;
  assign overflow_o  = overflow_q;
  assign wr_full_o   = (wr_cnt_q >= rows_i);

endmodule

// File: rtl/vxc_row_mem_server.sv
// Memory-side responder for the vXc row controller: fetches row pairs from
// operand memories A/B on request and stores result rows into the result RAM.
//
// Handshake: a read_again request is its rising edge; at most one fetch is in
// flight (rd_en cycle, then the RAM data cycle), and one extra request may be
// parked in the pending flag until the in-flight row has landed.
module vxc_row_mem_server
  import vxc_pkg::*;
#(
  parameter int element_width = ELEMENT_WIDTH,
  parameter int no_of_units   = NO_OF_UNITS,
  parameter int addr_width    = ADDR_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [31:0]                          total,
  input  logic                                 read_again,
  output logic [element_width*no_of_units-1:0] first_row_fixed,
  output logic [element_width*no_of_units-1:0] second_row_fixed,
  output logic                                 row_valid,
  output logic                                 mem_a_rd_en,
  output logic                                 mem_b_rd_en,
  output logic [addr_width-1:0]                mem_rd_addr,
  input  logic [element_width*no_of_units-1:0] mem_a_rdata,
  input  logic [element_width*no_of_units-1:0] mem_b_rdata,
  input  logic                                 result_mem_we,
  input  logic [element_width*no_of_units-1:0] vXc_add_8_output,
  output logic                                 res_we,
  output logic [addr_width-1:0]                res_addr,
  output logic [element_width*no_of_units-1:0] res_wdata,
  output logic                                 done,
  output logic                                 overflow,
  output logic [2:0]                           dbg_state
);

  localparam int RW = element_width * no_of_units;

  state_e                state_q, state_d;
  logic [31:0]           fetch_cnt_q, fetch_cnt_d;
  logic [31:0]           rows_q, rows_d;
  logic                  ra_prev_q;
  logic                  pend_q, pend_d;
  logic                  rd_en_q, rd_en_d;
  logic [addr_width-1:0] rd_addr_q, rd_addr_d;
  logic                  land_q;
  logic                  row_valid_q, row_valid_d;
  logic                  done_q, done_d;
  logic [RW-1:0]         first_q, second_q;

  logic        rise, start_ok, fetch_state, busy, req, issue, wr_full;
  logic [31:0] rows_new;

  assign rise        = read_again & ~ra_prev_q;
  assign start_ok    = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign rows_new    = total / 32'(no_of_units);
  assign fetch_state = (state_q == ST_PREFETCH) | (state_q == ST_SERVE);
  assign busy        = rd_en_q | land_q;
  assign req         = rise | pend_q;
  assign issue       = fetch_state & req & ~busy & (fetch_cnt_q < rows_q);

  // Next-state, fetch issue and pending-request bookkeeping.
  always_comb begin
    state_d     = state_q;
    fetch_cnt_d = fetch_cnt_q;
    rows_d      = rows_q;
    pend_d      = pend_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    row_valid_d = row_valid_q;
    done_d      = done_q;

    if (land_q) fetch_cnt_d = fetch_cnt_q + 32'd1;

    if (rd_en_q)     row_valid_d = 1'b0;
    else if (land_q) row_valid_d = 1'b1;

    // Park a request that arrives while a fetch is in flight; drop requests
    // beyond the last row or outside the fetch phase.
    if (!fetch_state || issue) pend_d = 1'b0;
    else if (busy)             pend_d = req;
    else                       pend_d = 1'b0;

    if (issue) begin
      rd_en_d   = 1'b1;
      rd_addr_d = fetch_cnt_q[addr_width-1:0];
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          rows_d      = rows_new;
          fetch_cnt_d = '0;
          pend_d      = 1'b0;
          if (rows_new == 32'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_PREFETCH;
            done_d    = 1'b0;
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
          end
        end
      end
      ST_PREFETCH: begin
        if (land_q) state_d = (fetch_cnt_d == rows_q) ? ST_DRAIN : ST_SERVE;
      end
      ST_SERVE: begin
        if (fetch_cnt_d == rows_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (wr_full) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; reset aborts any job and discards in-flight data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      fetch_cnt_q <= '0;
      rows_q      <= '0;
      ra_prev_q   <= 1'b0;
      pend_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      land_q      <= 1'b0;
      row_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_cnt_q <= fetch_cnt_d;
      rows_q      <= rows_d;
      ra_prev_q   <= read_again;
      pend_q      <= pend_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      land_q      <= rd_en_q;
      row_valid_q <= row_valid_d;
      done_q      <= done_d;
    end
  end

  // Row output registers capture RAM data in the cycle it is valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_q  <= '0;
      second_q <= '0;
    end else if (land_q) begin
      first_q  <= mem_a_rdata;
      second_q <= mem_b_rdata;
    end
  end

  vxc_result_writer #(
    .row_w      (RW),
    .addr_width (addr_width)
  ) u_writer (
    .clk             (clk),
    .reset           (reset),
    .clr_i           (start_ok),
    .rows_i          (rows_q),
    .result_mem_we_i (result_mem_we),
    .wdata_i         (vXc_add_8_output),
    .res_we_o        (res_we),
    .res_addr_o      (res_addr),
    .res_wdata_o     (res_wdata),
    .overflow_o      (overflow),
    .wr_full_o       (wr_full)
  );

  assign first_row_fixed  = first_q;
  assign second_row_fixed = second_q;
  assign row_valid        = row_valid_q;
  assign mem_a_rd_en      = rd_en_q;
  assign mem_b_rd_en      = rd_en_q;
  assign mem_rd_addr      = rd_addr_q;
  assign done             = done_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_vxc_row_mem_server.sv
// Bench for vxc_row_mem_server: table of whole jobs plus hand sequences for
// request timing, the pending flag, mid-job reset and zero-row jobs.
module tb_vxc_row_mem_server;

  localparam int RW = 512;
  localparam int AW = 10;

  logic          clk, reset, start, read_again, result_mem_we;
  logic [31:0]   total;
  logic [RW-1:0] first_row_fixed, second_row_fixed, mem_a_rdata, mem_b_rdata;
  logic [RW-1:0] vXc_add_8_output, res_wdata;
  logic          row_valid, mem_a_rd_en, mem_b_rd_en, res_we, done, overflow;
  logic [AW-1:0] mem_rd_addr, res_addr;
  logic [2:0]    dbg_state;

  vxc_row_mem_server dut (
    .clk(clk), .reset(reset), .start(start), .total(total), .read_again(read_again),
    .first_row_fixed(first_row_fixed), .second_row_fixed(second_row_fixed),
    .row_valid(row_valid), .mem_a_rd_en(mem_a_rd_en), .mem_b_rd_en(mem_b_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_a_rdata(mem_a_rdata), .mem_b_rdata(mem_b_rdata),
    .result_mem_we(result_mem_we), .vXc_add_8_output(vXc_add_8_output),
    .res_we(res_we), .res_addr(res_addr), .res_wdata(res_wdata),
    .done(done), .overflow(overflow), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  // ---------------- memory model ----------------
  function automatic logic [RW-1:0] pat(input logic [7:0] sel, input logic [AW-1:0] a);
    pat = {16{sel, 6'h0, a, 8'h3c}};
  endfunction

  always @(posedge clk) begin
    if (mem_a_rd_en) mem_a_rdata <= pat(8'ha5, mem_rd_addr);
    if (mem_b_rd_en) mem_b_rdata <= pat(8'hb7, mem_rd_addr);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int rd_seen  = 0;
  int wr_seen  = 0;
  logic [AW-1:0]    exp_addr_q[$];
  logic [AW-1:0]    exp_row_q[$];
  logic [AW+RW-1:0] exp_res_q[$];
  logic             prev_valid = 1'b0;

  int      rows_m, next_addr, wr_idx;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got an event with nothing expected", name);
  endtask

  // Monitor: every read strobe, every new row and every result write is
  // matched against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      prev_valid = 1'b0;
    end else begin
      if (mem_b_rd_en !== mem_a_rd_en) check("rd_en_b_eq_a", mem_b_rd_en, mem_a_rd_en);
      if (mem_a_rd_en) begin
        rd_seen++;
        if (exp_addr_q.size() == 0) unexpected("rd_en");
        else check("rd_addr", mem_rd_addr, exp_addr_q.pop_front());
      end
      if (row_valid && !prev_valid) begin
        if (exp_row_q.size() == 0) unexpected("row_valid");
        else begin
          logic [AW-1:0] a;
          a = exp_row_q.pop_front();
          check("first_row", first_row_fixed, pat(8'ha5, a));
          check("second_row", second_row_fixed, pat(8'hb7, a));
        end
      end
      prev_valid = row_valid;
      if (res_we) begin
        wr_seen++;
        if (exp_res_q.size() == 0) unexpected("res_we");
        else begin
          logic [AW+RW-1:0] e;
          e = exp_res_q.pop_front();
          check("res_addr", res_addr, e[AW+RW-1:RW]);
          check("res_wdata", res_wdata, e[RW-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, mem_a_rd_en, 0);
    check({tag, "_rd_addr"}, mem_rd_addr, 0);
    check({tag, "_row_valid"}, row_valid, 0);
    check({tag, "_first"}, first_row_fixed, 0);
    check({tag, "_second"}, second_row_fixed, 0);
    check({tag, "_res_we"}, res_we, 0);
    check({tag, "_res_addr"}, res_addr, 0);
    check({tag, "_res_wdata"}, res_wdata, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  task automatic flush_q();
    exp_addr_q.delete();
    exp_row_q.delete();
    exp_res_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0; read_again = 1'b0; result_mem_we = 1'b0;
    vXc_add_8_output = '0; total = '0;
    repeat (2) tick();
    flush_q();
    reset = 1'b1;
    tick();
    rd_seen = 0;
    wr_seen = 0;
  endtask

  task automatic start_job(input logic [31:0] t);
    total     = t;
    rows_m    = int'(t / 8);
    next_addr = 0;
    wr_idx    = 0;
    start     = 1'b1;
    if (rows_m > 0) begin
      exp_addr_q.push_back('0);
      exp_row_q.push_back('0);
      next_addr = 1;
    end
    tick();
    start = 1'b0;
  endtask

  task automatic push_req();
    if (next_addr < rows_m) begin
      exp_addr_q.push_back(AW'(next_addr));
      exp_row_q.push_back(AW'(next_addr));
      next_addr++;
    end
  endtask

  // One read_again rise, four cycles long in total.
  task automatic request();
    read_again = 1'b1;
    push_req();
    tick();
    read_again = 1'b0;
    repeat (3) tick();
  endtask

  task automatic write_row();
    logic [RW-1:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
    result_mem_we    = 1'b1;
    vXc_add_8_output = d;
    if (wr_idx < rows_m) begin
      exp_res_q.push_back({AW'(wr_idx), d});
      wr_idx++;
    end
    tick();
    result_mem_we = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_addr_q_left"}, exp_addr_q.size(), 0);
    check({tag, "_row_q_left"}, exp_row_q.size(), 0);
    check({tag, "_res_q_left"}, exp_res_q.size(), 0);
  endtask

  // ---------------- job table ----------------
  typedef struct {
    logic [31:0] total;
    int          n_req;
    int          n_we;
    int          exp_reads;
    int          exp_writes;
    logic        exp_ovf;
    logic        exp_done;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'd64, 8, 8, 8, 8, 1'b0, 1'b1};  // full 8-row job
    vecs[1] = '{32'd20, 3, 2, 2, 2, 1'b0, 1'b1};  // rises beyond the last row ignored
    vecs[2] = '{32'd20, 1, 3, 2, 2, 1'b1, 1'b1};  // third write suppressed, overflow
    vecs[3] = '{32'd5,  2, 0, 0, 0, 1'b0, 1'b1};  // zero rows
    vecs[4] = '{32'd7,  0, 1, 0, 0, 1'b1, 1'b1};  // zero rows, write overflows
    vecs[5] = '{32'd24, 1, 3, 2, 3, 1'b0, 1'b0};  // not all rows fetched: no done

    // initial reset state
    reset = 1'b0;
    start = 1'b0; read_again = 1'b0; result_mem_we = 1'b0;
    vXc_add_8_output = '0; total = '0;
    #3;
    check_all_zero("reset");

    for (int v = 0; v < 6; v++) begin
      do_reset();
      start_job(vecs[v].total);
      repeat (3) tick();
      for (int r = 0; r < vecs[v].n_req; r++) request();
      for (int w = 0; w < vecs[v].n_we; w++) write_row();
      repeat (4) tick();
      check($sformatf("vec%0d_reads", v), rd_seen, vecs[v].exp_reads);
      check($sformatf("vec%0d_writes", v), wr_seen, vecs[v].exp_writes);
      check($sformatf("vec%0d_overflow", v), overflow, vecs[v].exp_ovf);
      check($sformatf("vec%0d_done", v), done, vecs[v].exp_done);
      check_empty($sformatf("vec%0d", v));
    end

    // request timing, done only after the last write, restart from DONE
    do_reset();
    start_job(32'd64);
    check("prefetch_rd_en", mem_a_rd_en, 1);
    tick();
    check("prefetch_valid_low", row_valid, 0);
    tick();
    check("prefetch_valid_high", row_valid, 1);
    tick();
    for (int k = 1; k < 8; k++) begin
      read_again = 1'b1;
      push_req();
      tick();
      check("rise_rd_en", mem_a_rd_en, 1);
      read_again = 1'b0;
      tick();
      check("rise_valid_fall", row_valid, 0);
      tick();
      check("rise_valid_rise", row_valid, 1);
      tick();
    end
    read_again = 1'b1;
    tick();
    check("rise_at_limit_no_rd", mem_a_rd_en, 0);
    read_again = 1'b0;
    repeat (2) tick();
    check("limit_row_hold", first_row_fixed, pat(8'ha5, 10'd7));
    for (int w = 0; w < 7; w++) write_row();
    tick();
    check("done_before_last_write", done, 0);
    write_row();
    check("done_same_cycle_as_write", done, 0);
    tick();
    check("done_after_last_write", done, 1);
    write_row();
    tick();
    check("overflow_after_done", overflow, 1);
    check("overflow_keeps_done", done, 1);
    start_job(32'd20);
    check("restart_done_clear", done, 0);
    check("restart_overflow_clear", overflow, 0);
    repeat (3) tick();
    check_empty("restart");

    // two rises one cycle apart: the second waits in the pending flag
    do_reset();
    start_job(32'd64);
    repeat (3) tick();
    read_again = 1'b1;
    push_req();
    tick();
    read_again = 1'b0;
    tick();
    read_again = 1'b1;
    push_req();
    tick();
    check("pending_no_early_issue", mem_a_rd_en, 0);
    read_again = 1'b0;
    tick();
    check("pending_issue", mem_a_rd_en, 1);
    repeat (4) tick();
    check("pending_reads", rd_seen, 3);
    check_empty("pending");

    // reset pulsed while row 3 is being fetched, with a write in flight
    do_reset();
    start_job(32'd64);
    repeat (3) tick();
    request();
    request();
    read_again = 1'b1;
    push_req();
    write_row();
    read_again = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    flush_q();
    tick();
    reset = 1'b1;
    tick();
    start_job(32'd64);
    repeat (2) tick();
    check("refetch_valid", row_valid, 1);
    tick();
    check_empty("refetch");

    // zero-row job: done on the next cycle, no memory traffic
    do_reset();
    start_job(32'd5);
    check("zero_rows_done", done, 1);
    check("zero_rows_no_rd", mem_a_rd_en, 0);
    read_again = 1'b1;
    tick();
    read_again = 1'b0;
    repeat (3) tick();
    check("zero_rows_reads", rd_seen, 0);
    check("zero_rows_writes", wr_seen, 0);
    check_empty("zero_rows");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
